sd_req_arbiter: RTL and testbench
=================================

SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of sector requesters, legal range 2..4.
REQ-002 Parameter TIMEOUT, default 65535: cycles allowed from issue to sd_ack rise (TIMEOUT_EN builds only).
REQ-003 clk_sys  in  1  system clock; every port is synchronous to it; clk_sd of the SD channel is tied to clk_sys.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_rd  in  NREQ  per-requester sector read request, level, held until grant_done.
REQ-006 req_wr  in  NREQ  per-requester sector write request, level, held until grant_done.
REQ-007 req_lba  in  NREQ*32  per-requester sector address; requester i uses bits [32i+31:32i].
REQ-008 req_din  in  NREQ*8  per-requester write data byte, same slicing at 8 bits.
REQ-009 sd_lba  out  32  address to the SD channel.
REQ-010 sd_rd  out  1  read command to the SD channel.
REQ-011 sd_wr  out  1  write command to the SD channel.
REQ-012 sd_ack  in  1  SD channel transfer-active flag.
REQ-013 sd_dout_strobe  in  1  SD channel read-byte strobe.
REQ-014 sd_din_strobe  in  1  SD channel write-byte fetch strobe.
REQ-015 sd_din  out  8  write byte to the SD channel, muxed from the owner.
REQ-016 grant_ack  out  NREQ  sd_ack routed to the owner only.
REQ-017 grant_dout_strobe  out  NREQ  sd_dout_strobe routed to the owner only.
REQ-018 grant_din_strobe  out  NREQ  sd_din_strobe routed to the owner only.
REQ-019 grant_done  out  NREQ  one-cycle pulse to the owner at transfer end.
REQ-020 grant_err  out  NREQ  one-cycle timeout pulse; tied 0 without TIMEOUT_EN.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 sd_dout and sd_buff_addr are broadcast to all requesters outside this block.

Function
REQ-023 The FSM SHALL use four states: IDLE, ISSUE, XFER, DONE.
REQ-024 IDLE: when any requester is pending, select the owner round-robin starting at last_owner+1 mod NREQ, latch its lba and op, and go to ISSUE on the next cycle.
REQ-025 When req_rd and req_wr are both high for one requester, the read is served first; the write stays pending.
REQ-026 ISSUE: drive sd_lba=latched lba and sd_rd or sd_wr high; on sd_ack=1, drop sd_rd/sd_wr in the same cycle and go to XFER.
REQ-027 ISSUE: if the owner drops the latched request before sd_ack, drop sd_rd/sd_wr and return to IDLE with no done pulse; last_owner is updated.
REQ-028 XFER: route ack/strobes to the owner with zero-cycle combinational latency; sd_din=req_din[owner] at all times while not IDLE; on sd_ack=0 go to DONE.
REQ-029 DONE: pulse grant_done[owner] for one cycle, set last_owner=owner, go to IDLE; a new grant is possible no earlier than the cycle after DONE.
REQ-030 Non-owners SHALL see grant_ack, grant_dout_strobe, grant_din_strobe, grant_done and grant_err all at 0.
REQ-031 sd_lba SHALL stay stable from the ISSUE entry until DONE exit, even if req_lba changes.

Reset
REQ-032 Reset SHALL force IDLE, last_owner=NREQ-1 (so the first grant goes to requester 0), sd_rd=sd_wr=0, sd_lba=0, all grant_* outputs=0, busy=0, and timeout counter=0.
REQ-033 Reset asserted mid-transfer SHALL take effect immediately; the requester re-requests after reset.

Configuration
REQ-034 Macro SD_ARB_TIMEOUT_EN defined: a 16-bit counter runs in ISSUE; at count==TIMEOUT, drop sd_rd/sd_wr, pulse grant_err[owner], and go to IDLE with last_owner=owner.
REQ-035 Macro SD_ARB_TIMEOUT_EN undefined: there is no counter, ISSUE waits indefinitely, and grant_err=0.

Structure
REQ-036 Package sd_arb_pkg SHALL hold the state enum, the NREQ_MAX=4 constant, and the op encoding (OP_RD, OP_WR).
REQ-037 Sub-module sd_rr_pick SHALL be the combinational round-robin selector (pending vector and last_owner in; owner index and valid out).

Verification
REQ-038 Single read: req_rd[0]=1, lba=0x00001234; ack rises 5 cycles later and falls after 512 dout strobes -> sd_rd high 1..6 cycles, grant_dout_strobe[0] gets 512 pulses, one grant_done[0], sd_lba=0x1234 throughout.
REQ-039 Contention: req_rd[0] and req_rd[1] rise in the same cycle after reset -> requester 0 served, then 1; a further simultaneous request -> 0 served next (rotation follows last_owner=1).
REQ-040 Write data: req_wr[1]=1, req_din[1]=0xA5 -> sd_wr asserted, sd_din=0xA5, grant_din_strobe[1] mirrors sd_din_strobe, grant_*[0] stays 0.
REQ-041 Rd+wr on one requester: req_rd[0]=req_wr[0]=1 -> read completes first, then the write issues after a DONE->IDLE->ISSUE sequence.
REQ-042 Abort and reset: the requester drops req in ISSUE -> IDLE with no done pulse; reset asserted during XFER -> all outputs 0 next edge.
REQ-043 SD_ARB_TIMEOUT_EN with TIMEOUT=100 and no sd_ack -> grant_err[owner] pulses at cycle 100 of ISSUE and sd_rd drops.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types for the SD sector-request arbiter: FSM states, requester
// index type and the latched operation encoding.
package sd_arb_pkg;

   localparam int NREQ_MAX = 4;

   typedef logic [$clog2(NREQ_MAX)-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/sd_req_arbiter_if.sv
// Requester-side and SD-channel-side signals of the arbiter. The master
// modport is the arbiter itself; slave is the environment around it.
interface sd_req_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]    req_rd;
   logic [NREQ-1:0]    req_wr;
   logic [NREQ*32-1:0] req_lba;
   logic [NREQ*8-1:0]  req_din;
   logic [31:0]        sd_lba;
   logic               sd_rd;
   logic               sd_wr;
   logic               sd_ack;
   logic               sd_dout_strobe;
   logic               sd_din_strobe;
   logic [7:0]         sd_din;
   logic [NREQ-1:0]    grant_ack;
   logic [NREQ-1:0]    grant_dout_strobe;
   logic [NREQ-1:0]    grant_din_strobe;
   logic [NREQ-1:0]    grant_done;
   logic [NREQ-1:0]    grant_err;
   logic               busy;

   modport master (
      input  req_rd, req_wr, req_lba, req_din, sd_ack, sd_dout_strobe, sd_din_strobe,
      output sd_lba, sd_rd, sd_wr, sd_din, grant_ack, grant_dout_strobe,
             grant_din_strobe, grant_done, grant_err, busy
   );

   modport slave (
      output req_rd, req_wr, req_lba, req_din, sd_ack, sd_dout_strobe, sd_din_strobe,
      input  sd_lba, sd_rd, sd_wr, sd_din, grant_ack, grant_dout_strobe,
             grant_din_strobe, grant_done, grant_err, busy
   );
endinterface

// File: rtl/sd_rr_pick.sv
// Combinational round-robin selector: first pending requester found after
// last_owner, wrapping modulo NREQ.
module sd_rr_pick
   import sd_arb_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] pending,
   input  idx_t            last_owner,
   output idx_t            owner,
   output logic            valid
);

   int best_s;
   int dist_s;

   // Pick the pending requester with the smallest rotation distance.
   always_comb begin
      owner  = last_owner;
      valid  = 1'b0;
      best_s = NREQ;
      dist_s = 0;
      for (int i = 0; i < NREQ; i++) begin
         dist_s = (i + NREQ - 1 - int'(last_owner)) % NREQ;
         if (pending[i] && (dist_s < best_s)) begin
            best_s = dist_s;
            owner  = idx_t'(i);
            valid  = 1'b1;
         end else begin
            best_s = best_s;
         end
      end
   end

endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SD sector channel among NREQ requesters.
// Optional issue timeout is built when SD_ARB_TIMEOUT_EN is defined.
module sd_req_arbiter
   import sd_arb_pkg::*;
#(
   parameter int NREQ = 2
`ifdef SD_ARB_TIMEOUT_EN
   , parameter int TIMEOUT = 65535
`endif
) (
   input logic         clk_sys,
   input logic         reset,
   sd_req_arbiter_if.master bus
);

   state_t          state_q, state_d;
   idx_t            owner_q, owner_d;
   idx_t            last_q, last_d;
   op_t             op_q, op_d;
   logic [31:0]     lba_q, lba_d;
   logic            cmd_q, cmd_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [NREQ-1:0] err_q, err_d;
`ifdef SD_ARB_TIMEOUT_EN
   logic [15:0]     cnt_q, cnt_d;
`endif

   idx_t            pick_owner_s;
   logic            pick_valid_s;
   logic [NREQ-1:0] pick_oh_s;
   logic [NREQ-1:0] own_oh_s;
   logic [31:0]     pick_lba_s;
   logic [7:0]      own_din_s;
   logic            held_s;
   logic            busy_s;

   sd_rr_pick #(.NREQ(NREQ)) u_pick (
      .pending    (bus.req_rd | bus.req_wr),
      .last_owner (last_q),
      .owner      (pick_owner_s),
      .valid      (pick_valid_s)
   );

   // One-hot decodes and per-requester muxes for the candidate and the owner.
   always_comb begin
      pick_oh_s  = '0;
      own_oh_s   = '0;
      pick_lba_s = 32'd0;
      own_din_s  = 8'd0;
      for (int i = 0; i < NREQ; i++) begin
         pick_oh_s[i] = pick_valid_s & (pick_owner_s == idx_t'(i));
         own_oh_s[i]  = (owner_q == idx_t'(i));
         pick_lba_s   = pick_lba_s | (bus.req_lba[32*i +: 32] & {32{pick_oh_s[i]}});
         own_din_s    = own_din_s | (bus.req_din[8*i +: 8] & {8{own_oh_s[i]}});
      end
      held_s = (op_q == OP_RD) ? |(bus.req_rd & own_oh_s) : |(bus.req_wr & own_oh_s);
   end

   // Next-state logic; sd_ack wins over a simultaneous request drop.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      op_d    = op_q;
      lba_d   = lba_q;
      cmd_d   = cmd_q;
      done_d  = '0;
      err_d   = '0;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_valid_s) begin
               state_d = ISSUE;
               owner_d = pick_owner_s;
               op_d    = (|(bus.req_rd & pick_oh_s)) ? OP_RD : OP_WR;
               lba_d   = pick_lba_s;
               cmd_d   = 1'b1;
`ifdef SD_ARB_TIMEOUT_EN
               cnt_d   = 16'd1;
`endif
            end else begin
               cmd_d   = 1'b0;
            end
         end
         ISSUE: begin
            if (bus.sd_ack) begin
               state_d = XFER;
               cmd_d   = 1'b0;
            end else if (!held_s) begin
               state_d = IDLE;
               cmd_d   = 1'b0;
               last_d  = owner_q;
`ifdef SD_ARB_TIMEOUT_EN
            end else if (cnt_q == 16'(TIMEOUT)) begin
               state_d = IDLE;
               cmd_d   = 1'b0;
               last_d  = owner_q;
               err_d   = own_oh_s;
            end else begin
               cnt_d   = cnt_q + 16'd1;
            end
`else
            end else begin
               cmd_d   = 1'b1;
            end
`endif
         end
         XFER: begin
            if (!bus.sd_ack) begin
               state_d = DONE;
               done_d  = own_oh_s;
            end else begin
               state_d = XFER;
            end
         end
         DONE: begin
            state_d = IDLE;
            last_d  = owner_q;
         end
         default: begin
            state_d = IDLE;
            cmd_d   = 1'b0;
         end
      endcase
   end

   // State and registered command/pulse flops.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= idx_t'(0);
         last_q  <= idx_t'(NREQ - 1);
         op_q    <= OP_RD;
         lba_q   <= 32'd0;
         cmd_q   <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
`ifdef SD_ARB_TIMEOUT_EN
         cnt_q   <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         op_q    <= op_d;
         lba_q   <= lba_d;
         cmd_q   <= cmd_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef SD_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign busy_s                = (state_q != IDLE);
   assign bus.busy              = busy_s;
   assign bus.sd_lba            = lba_q;
   // The command falls combinationally in the same cycle sd_ack rises.
   assign bus.sd_rd             = cmd_q & (op_q == OP_RD) & ~bus.sd_ack;
   assign bus.sd_wr             = cmd_q & (op_q == OP_WR) & ~bus.sd_ack;
   assign bus.sd_din            = busy_s ? own_din_s : 8'd0;
   assign bus.grant_ack         = own_oh_s & {NREQ{bus.sd_ack & busy_s}};
   assign bus.grant_dout_strobe = own_oh_s & {NREQ{bus.sd_dout_strobe & busy_s}};
   assign bus.grant_din_strobe  = own_oh_s & {NREQ{bus.sd_din_strobe & busy_s}};
   assign bus.grant_done        = done_q;
   assign bus.grant_err         = err_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed plus randomized bench for sd_req_arbiter against a transaction-level
// round-robin model.
module tb_sd_req_arbiter;

   localparam int NREQ = 2;

   logic clk_sys = 1'b0;
   logic reset;
   always #5 clk_sys = ~clk_sys;

   sd_req_arbiter_if #(.NREQ(NREQ)) bus();

`ifdef SD_ARB_TIMEOUT_EN
   sd_req_arbiter #(.NREQ(NREQ), .TIMEOUT(100)) dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));
`else
   sd_req_arbiter #(.NREQ(NREQ)) dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [NREQ-1:0] m_rd, m_wr;
   logic [31:0]     m_lba [NREQ];
   logic [7:0]      m_din [NREQ];
   int              m_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.req_rd = m_rd;
      bus.req_wr = m_wr;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_lba[32*i +: 32] = m_lba[i];
         bus.req_din[8*i +: 8]   = m_din[i];
      end
   endtask

   function automatic int model_pick();
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (m_last + k) % NREQ;
         if (m_rd[c] || m_wr[c]) return c;
      end
      return -1;
   endfunction

   // Full transaction: d ISSUE cycles before ack, n strobes in XFER.
   task automatic xfer(input int d, input int n);
      int o, hi, cnt;
      bit rd;
      logic [NREQ-1:0] oh;
      logic [31:0] lat;
      o = model_pick();
      if (o < 0) return;
      rd = m_rd[o];
      oh = '0;
      oh[o] = 1'b1;
      lat = m_lba[o];
      @(negedge clk_sys);
      chk("busy_issue", bus.busy, 1);
      chk("sd_rd", bus.sd_rd, rd);
      chk("sd_wr", bus.sd_wr, !rd);
      chk("sd_lba", bus.sd_lba, lat);
      chk("sd_din", bus.sd_din, m_din[o]);
      hi = 0;
      for (int c = 0; c < d; c++) begin
         if (bus.sd_rd == rd && bus.sd_wr == !rd) hi++;
         if (c < d - 1) @(negedge clk_sys);
      end
      chk("cmd_cycles", hi, d);
      bus.sd_ack = 1'b1;
      #1;
      chk("cmd_drop_on_ack", bus.sd_rd | bus.sd_wr, 0);
      chk("grant_ack", bus.grant_ack, oh);
      cnt = 0;
      for (int s = 0; s < n; s++) begin
         @(negedge clk_sys);
         m_lba[o] = $urandom;
         drive();
         if (rd) bus.sd_dout_strobe = 1'b1;
         else    bus.sd_din_strobe  = 1'b1;
         #1;
         chk("grant_strobe", rd ? bus.grant_dout_strobe : bus.grant_din_strobe, oh);
         chk("other_strobe", rd ? bus.grant_din_strobe : bus.grant_dout_strobe, 0);
         chk("sd_lba_stable", bus.sd_lba, lat);
         if (!rd) chk("sd_din_xfer", bus.sd_din, m_din[o]);
         if (rd ? bus.grant_dout_strobe[o] : bus.grant_din_strobe[o]) cnt++;
      end
      chk("strobe_count", cnt, n);
      @(negedge clk_sys);
      bus.sd_dout_strobe = 1'b0;
      bus.sd_din_strobe  = 1'b0;
      bus.sd_ack         = 1'b0;
      @(negedge clk_sys);
      chk("grant_done", bus.grant_done, oh);
      chk("lba_at_done", bus.sd_lba, lat);
      if (rd) m_rd[o] = 1'b0;
      else    m_wr[o] = 1'b0;
      m_last = o;
      drive();
      @(negedge clk_sys);
      chk("done_clear", bus.grant_done, 0);
      chk("busy_idle", bus.busy, 0);
   endtask

   // Owner drops its request while still waiting for sd_ack.
   task automatic abort_xfer(input int d);
      int o;
      bit rd;
      o = model_pick();
      if (o < 0) return;
      rd = m_rd[o];
      @(negedge clk_sys);
      chk("abort_cmd", rd ? bus.sd_rd : bus.sd_wr, 1);
      repeat (d - 1) @(negedge clk_sys);
      if (rd) m_rd[o] = 1'b0;
      else    m_wr[o] = 1'b0;
      m_last = o;
      drive();
      @(negedge clk_sys);
      chk("abort_busy", bus.busy, 0);
      chk("abort_cmd_drop", bus.sd_rd | bus.sd_wr, 0);
      chk("abort_no_done", bus.grant_done, 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.sd_ack = 1'b0;
      bus.sd_dout_strobe = 1'b0;
      bus.sd_din_strobe = 1'b0;
      m_rd = '0;
      m_wr = '0;
      for (int i = 0; i < NREQ; i++) begin
         m_lba[i] = 32'd0;
         m_din[i] = 8'd0;
      end
      m_last = NREQ - 1;
      drive();
      repeat (2) @(negedge clk_sys);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cmd", bus.sd_rd | bus.sd_wr, 0);
      chk("rst_lba", bus.sd_lba, 0);
      chk("rst_done", bus.grant_done, 0);
      chk("rst_err", bus.grant_err, 0);
      chk("rst_ack", bus.grant_ack, 0);
      reset = 1'b0;
      @(negedge clk_sys);

      // Single read of 512 bytes.
      m_lba[0] = 32'h0000_1234;
      m_rd[0] = 1'b1;
      drive();
      xfer(5, 512);

      // Contention, twice, to observe rotation.
      m_rd = 2'b11;
      drive();
      xfer(2, 3);
      xfer(3, 2);
      m_rd = 2'b11;
      drive();
      xfer(1, 1);
      xfer(2, 2);

      // Write from requester 1.
      m_wr[1] = 1'b1;
      m_din[1] = 8'hA5;
      drive();
      xfer(3, 4);

      // Read and write pending on one requester.
      m_rd[0] = 1'b1;
      m_wr[0] = 1'b1;
      m_din[0] = 8'h3C;
      drive();
      xfer(2, 3);
      xfer(2, 3);

      // Abort in ISSUE.
      m_rd[1] = 1'b1;
      drive();
      abort_xfer(3);

      // Reset during XFER.
      m_rd[0] = 1'b1;
      m_lba[0] = $urandom;
      drive();
      @(negedge clk_sys);
      bus.sd_ack = 1'b1;
      @(negedge clk_sys);
      bus.sd_dout_strobe = 1'b1;
      #1;
      chk("pre_rst_strobe", bus.grant_dout_strobe, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_cmd", bus.sd_rd | bus.sd_wr, 0);
      chk("mid_rst_lba", bus.sd_lba, 0);
      chk("mid_rst_ack", bus.grant_ack, 0);
      chk("mid_rst_strobe", bus.grant_dout_strobe, 0);
      chk("mid_rst_din", bus.sd_din, 0);
      bus.sd_ack = 1'b0;
      bus.sd_dout_strobe = 1'b0;
      @(negedge clk_sys);
      reset = 1'b0;
      m_last = NREQ - 1;
      xfer(2, 2);

`ifdef SD_ARB_TIMEOUT_EN
      begin
         int hi;
         bit got;
         hi = 0;
         got = 1'b0;
         m_rd[1] = 1'b1;
         drive();
         for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk_sys);
            if (bus.grant_err != 0) got = 1'b1;
            else if (bus.sd_rd) hi++;
         end
         chk("timeout_seen", got, 1);
         chk("timeout_cycles", hi, 100);
         chk("timeout_err", bus.grant_err, 2'b10);
         chk("timeout_cmd", bus.sd_rd, 0);
         m_rd[1] = 1'b0;
         m_last = 1;
         drive();
         @(negedge clk_sys);
         chk("timeout_err_clear", bus.grant_err, 0);
      end
`endif

      // Randomized rounds.
      for (int r = 0; r < 25; r++) begin
         m_rd = NREQ'($urandom_range(0, 3));
         m_wr = NREQ'($urandom_range(0, 3));
         if ((m_rd | m_wr) == '0) m_rd[$urandom_range(0, NREQ - 1)] = 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            m_lba[i] = $urandom;
            m_din[i] = 8'($urandom);
         end
         drive();
         while ((m_rd | m_wr) != '0) begin
            if ($urandom_range(0, 5) == 0) abort_xfer($urandom_range(1, 3));
            else xfer($urandom_range(1, 4), $urandom_range(1, 5));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
